alu_share_arbiter: RTL and testbench

- Shares one combinational ALU (add/sub/and/or, flags N/Z/C/V) between NUM_REQ requesters, e.g. the execute stage and a multi-cycle address/branch helper.
- Arbitrates with a valid/ready handshake, registers operands toward the ALU, captures result and flags, and returns them to the granted requester with response backpressure.
- Only one operation is in flight at a time.

---
 rtl/alu_share_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between NUM_REQ requesters.
// Round-robin grant by default; define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
//
// state | meaning
// IDLE  | arbitrating, req_ready offered to the winner
// EXEC  | operands on the ALU, result captured at end of cycle
// RESP  | response held on rsp_* until the granted requester accepts
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_cntrl,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero,
  input  logic                     alu_negative,
  input  logic                     alu_carry,
  input  logic                     alu_over_flow,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [3:0]               rsp_flags,
  output logic                     busy
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [IDXW-1:0] gnt_q;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_found;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDXW'(i);
      end
    end
  end
`else
  logic [IDXW-1:0] ptr;
  logic [IDXW:0]   cand;

  // Search upward from the pointer with wrap-around; first hit wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDXW+1)'(i);
      if (cand >= (IDXW+1)'(NUM_REQ))
        cand = cand - (IDXW+1)'(NUM_REQ);
      if (!gnt_found && req_valid[cand[IDXW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDXW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == RESP && rsp_ready[gnt_q]) begin
      ptr <= (gnt_q == IDXW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found)
      req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cntrl  <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            alu_a     <= req_a[gnt_idx*WIDTH +: WIDTH];
            alu_b     <= req_b[gnt_idx*WIDTH +: WIDTH];
            alu_cntrl <= req_op[gnt_idx*3 +: 3];
            gnt_q     <= gnt_idx;
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= {alu_negative, alu_zero, alu_carry, alu_over_flow};
          rsp_valid  <= NUM_REQ'(1) << gnt_q;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[gnt_q]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: table-driven single ops plus contention,
// backpressure and mid-operation reset sequences. Provides its own ALU model.
module tb_alu_share_arbiter;
  localparam int W = 32;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*3-1:0] req_op;
  logic [W-1:0]   alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]     alu_cntrl;
  logic           alu_zero, alu_negative, alu_carry, alu_over_flow, busy;
  logic [3:0]     rsp_flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_over_flow(alu_over_flow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  // Reference ALU: carry on subtract means "no borrow".
  logic [W:0] sum;
  always_comb begin
    sum           = '0;
    alu_carry     = 1'b0;
    alu_over_flow = 1'b0;
    case (alu_cntrl)
      3'b000: begin
        sum           = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry     = sum[W];
        alu_over_flow = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
      end
      3'b001: begin
        sum           = {1'b0, alu_a} + {1'b0, ~alu_b} + (W+1)'(1);
        alu_carry     = sum[W];
        alu_over_flow = (alu_a[W-1] != alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
      end
      3'b010:  sum = {1'b0, alu_a & alu_b};
      3'b011:  sum = {1'b0, alu_a | alu_b};
      default: sum = '0;
    endcase
    alu_result   = sum[W-1:0];
    alu_negative = sum[W-1];
    alu_zero     = (sum[W-1:0] == '0);
  end

  typedef struct {
    int         idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] res;
    logic [3:0]   flg;   // {N, Z, C, V}
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_req_ready"},  64'(req_ready),  64'd0);
    chk({pfx, "_rsp_valid"},  64'(rsp_valid),  64'd0);
    chk({pfx, "_alu_a"},      64'(alu_a),      64'd0);
    chk({pfx, "_alu_b"},      64'(alu_b),      64'd0);
    chk({pfx, "_alu_cntrl"},  64'(alu_cntrl),  64'd0);
    chk({pfx, "_rsp_result"}, 64'(rsp_result), 64'd0);
    chk({pfx, "_rsp_flags"},  64'(rsp_flags),  64'd0);
    chk({pfx, "_busy"},       64'(busy),       64'd0);
  endtask

  task automatic drive_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op);
    req_a[idx*W +: W]  = a;
    req_b[idx*W +: W]  = b;
    req_op[idx*3 +: 3] = op;
    req_valid[idx]     = 1'b1;
  endtask

  task automatic wait_ready(input int idx);
    int n;
    n = 0;
    while (req_ready[idx] !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: req_ready=%b never granted idx %0d", req_ready, idx);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    rsp_ready = '1;
    req_valid = '0;
    drive_req(v.idx, v.a, v.b, v.op);
    #1;
    wait_ready(v.idx);
    chk($sformatf("v%0d_ready", k), 64'(req_ready), 64'(1) << v.idx);
    cyc();
    req_valid = '0;
    #1;
    chk($sformatf("v%0d_alu_a", k),     64'(alu_a),     64'(v.a));
    chk($sformatf("v%0d_alu_b", k),     64'(alu_b),     64'(v.b));
    chk($sformatf("v%0d_alu_cntrl", k), 64'(alu_cntrl), 64'(v.op));
    chk($sformatf("v%0d_exec_rsp", k),  64'(rsp_valid), 64'd0);
    chk($sformatf("v%0d_busy", k),      64'(busy),      64'd1);
    cyc();
    chk($sformatf("v%0d_rsp_valid", k), 64'(rsp_valid),  64'(1) << v.idx);
    chk($sformatf("v%0d_result", k),    64'(rsp_result), 64'(v.res));
    chk($sformatf("v%0d_flags", k),     64'(rsp_flags),  64'(v.flg));
    cyc();
    chk($sformatf("v%0d_idle_busy", k), 64'(busy),      64'd0);
    chk($sformatf("v%0d_idle_rsp", k),  64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int nacc;
    int last;
    int exp_g;

    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;

    vecs[0] = '{0, 32'd5,          32'd3,          3'b000, 32'd8,          4'b0000};
    vecs[1] = '{1, 32'd3,          32'd5,          3'b001, 32'hFFFF_FFFE,  4'b1000};
    vecs[2] = '{1, 32'd5,          32'd5,          3'b001, 32'h0000_0000,  4'b0110};
    vecs[3] = '{0, 32'h7FFF_FFFF,  32'd1,          3'b000, 32'h8000_0000,  4'b1001};
    vecs[4] = '{1, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  3'b010, 32'h00F0_00F0,  4'b0000};
    vecs[5] = '{0, 32'h0000_0000,  32'h0000_0000,  3'b011, 32'h0000_0000,  4'b0100};
    vecs[6] = '{1, 32'hFFFF_FFFF,  32'd1,          3'b000, 32'h0000_0000,  4'b0110};

    #2 rst = 1'b1;
    #1 check_zero("reset");
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // Contention: both requesters valid continuously from pointer 0.
    do_reset();
    rsp_ready = '1;
    drive_req(0, 32'd10, 32'd1, 3'b000);
    drive_req(1, 32'd20, 32'd2, 3'b000);
    #1;
    nacc = 0;
    last = 0;
    for (int c = 0; c < 20 && nacc < 4; c++) begin
      chk($sformatf("cont_onehot0_c%0d", c), 64'($onehot0(req_ready)), 64'd1);
      if (req_ready != '0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = 0;
`else
        exp_g = nacc % 2;
`endif
        chk($sformatf("cont_grant%0d", nacc), 64'(req_ready), 64'(1) << exp_g);
        if (nacc > 0) chk($sformatf("cont_space%0d", nacc), 64'(c - last), 64'd3);
        last = c;
        nacc++;
      end
      cyc();
    end
    chk("cont_accepts", 64'(nacc), 64'd4);
    req_valid = '0;

    // Backpressure on requester 0 while requester 1 waits.
    do_reset();
    rsp_ready = '0;
    drive_req(0, 32'd10, 32'd20, 3'b000);
    #1;
    wait_ready(0);
    chk("bp_ready0", 64'(req_ready), 64'h1);
    cyc();
    req_valid = '0;
    drive_req(1, 32'd1, 32'd2, 3'b000);
    #1;
    chk("bp_exec_ready", 64'(req_ready), 64'd0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_valid%0d", i),  64'(rsp_valid),  64'h1);
      chk($sformatf("bp_hold_result%0d", i), 64'(rsp_result), 64'd30);
      chk($sformatf("bp_hold_flags%0d", i),  64'(rsp_flags),  64'd0);
      chk($sformatf("bp_hold_ready%0d", i),  64'(req_ready),  64'd0);
      cyc();
    end
    rsp_ready = 2'b10;
    #1;
    cyc();
    chk("bp_ignore_other", 64'(rsp_valid), 64'h1);
    chk("bp_ignore_busy",  64'(busy),      64'd1);
    rsp_ready = 2'b01;
    #1;
    cyc();
    rsp_ready = '0;
    #1;
    chk("bp_released_valid", 64'(rsp_valid), 64'd0);
    chk("bp_released_busy",  64'(busy),      64'd0);
    chk("bp_ready1",         64'(req_ready), 64'h2);
    cyc();
    req_valid = '0;
    #1;
    chk("bp_alu_a1", 64'(alu_a), 64'd1);
    chk("bp_alu_b1", 64'(alu_b), 64'd2);
    cyc();
    cyc();
    chk("bp_rsp1_valid",  64'(rsp_valid),  64'h2);
    chk("bp_rsp1_result", 64'(rsp_result), 64'd3);
    rsp_ready = 2'b10;
    cyc();
    rsp_ready = '0;

    // Reset while in EXEC.
    rsp_ready = '1;
    drive_req(1, 32'd7, 32'd8, 3'b000);
    #1;
    wait_ready(1);
    cyc();
    req_valid = '0;
    #1;
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_alu_a", 64'(alu_a), 64'd7);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("post_rsp%0d", i),   64'(rsp_valid), 64'd0);
      chk($sformatf("post_busy%0d", i),  64'(busy),      64'd0);
      chk($sformatf("post_ready%0d", i), 64'(req_ready), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
